matrix_subtr_seq: RTL and testbench
===================================

# matrix_subtr_seq

Streaming controller that sequences an element-wise matrix subtraction C = A − B for the neural-net datapath (weight/gradient update path). On a `start` pulse it walks a ROWS×COLS matrix in row-major order and issues reads to two operand memories. It subtracts each returned element pair in a single shared subtractor and emits results on a valid/ready write stream. A `done` pulse marks completion. One element per cycle when the sink is ready; backpressure stalls the whole pipeline without losing or duplicating elements.

## Interface
- `ROWS`, 3: matrix rows.
- `COLS`, 2: matrix columns.
- `DW`, 4: signed element width, two's complement.
- `SAT`, 0: 0 = wrap-around result, 1 = saturate to [−2^(DW−1), 2^(DW−1)−1].
- Derived: N = ROWS·COLS; AW = max(1, $clog2(N)).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: **synchronous, active-low reset**.
- `start` in 1: begin a pass; sampled only in IDLE.
- `busy` out 1: pass in progress.
- `done` out 1: one-cycle pulse after last result accepted.
- `rd_en` out 1: read strobe to both operand memories.
- `rd_addr` out AW: row-major element index r·COLS+c.
- `a_data` in DW: A element, valid 1 cycle after `rd_en`; held while `rd_en` low.
- `b_data` in DW: B element, same timing as `a_data`.
- `c_valid` out 1: result valid.
- `c_ready` in 1: sink accepts result.
- `c_addr` out AW: index of result.
- `c_data` out DW: A−B for that index.

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE → RUN on `start`=1.
  - RUN → DRAIN after read index N−1 is issued.
  - DRAIN → IDLE on handshake (`c_valid`&`c_ready`) with `c_addr`=N−1.
- Pipeline enable: adv = !`c_valid` | `c_ready`.
- Stage 0 (issue): in RUN, `rd_en` = adv. On each issue, the read index increments 0..N−1 and never wraps past N−1.
- Stage 1 (memory return): `s1_valid`/`s1_addr` update only on adv, taking `s1_valid` <= `rd_en`. Memory data is held when `rd_en` is low, so a stalled stage 1 stays consistent.
- Stage 2 (output): on adv, `c_valid` <= `s1_valid`, `c_addr` <= `s1_addr`, `c_data` <= sub(`a_data`, `b_data`).
- When adv = 0, all stage registers hold.
- Arithmetic: compute a DW+1-bit signed difference.
  - SAT=0: truncate to DW bits (wrap).
  - SAT=1: clamp to the DW range.
- `busy` = 1 in RUN and DRAIN.
- `done` = registered pulse in the cycle after the final handshake. `busy` falls in that same cycle.
- `start` while `busy` is ignored. `start` in the `done` cycle is accepted (FSM is already IDLE).
- Reset (any state, including mid-pass):
  - Next cycle: IDLE, all pipeline valids cleared.
  - All outputs 0: `busy`, `done`, `rd_en`, `rd_addr`, `c_valid`, `c_addr`, `c_data`.
  - No `done` is emitted for the aborted pass.

## Timing
- `start` sampled at edge k:
  - `rd_en`=1, `rd_addr`=0 during cycle k+1.
  - Result index 0 valid during cycle k+3.
- Latency is 2 cycles from read issue to `c_valid`.
- With `c_ready` held at 1:
  - Results appear in cycles k+3..k+N+2.
  - `done` appears in cycle k+N+3.
- Each cycle with `c_valid`=1 and `c_ready`=0 adds exactly one cycle to the total. `c_data`/`c_addr` hold stable during the stall.
- `c_ready` may be asserted before `c_valid`. No combinational path from `c_ready` to `c_valid`/`c_data`. `rd_en` depends combinationally on `c_ready` through adv.

## Structure
- Shared package `nn_pkg`:
  - state enum (IDLE/RUN/DRAIN);
  - function `sub_wrap_sat(a, b, sat)` for DW-bit signed subtract, reused by the other matrix-op sequencers.
- One sub-module `matrix_elem_subtr`: combinational DW-bit signed subtractor with the SAT option, instantiated once as the shared arithmetic unit.
- FSM, counters and pipeline registers live in the top module.

## Test plan
Defaults unless stated: ROWS=3, COLS=2, DW=4.
1. SAT=0, `c_ready`=1. A={1,2,3,4,5,6}, B={0,1,1,1,1,1}, `start` at edge 0 → `c_data` 1,1,2,3,4,5 with `c_addr` 0..5 in cycles 3..8; `done` in cycle 9 only; `busy` high cycles 1..8.
2. Overflow, one element. A=7,B=−8 → SAT=0 gives −1; SAT=1 gives 7. A=−8,B=1 → SAT=0 gives 7; SAT=1 gives −8.
3. Backpressure. `c_ready`=0 for 3 cycles while `c_addr`=2 is valid → `c_addr`/`c_data` stable; `rd_en` low; all six results delivered exactly once in order; `done` in cycle 12.
4. `start` pulsed again in cycle 4 of a pass → ignored; exactly one `done`, six results.
5. `rst_n`=0 at cycle 5 mid-pass → next cycle all outputs 0, FSM IDLE, no `done`. A fresh `start` then completes a normal pass with results identical to scenario 1.
6. Back-to-back passes. `start` asserted in the `done` cycle → second pass starts next cycle, `rd_addr` restarts at 0.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and arithmetic helpers for the neural-net matrix-op sequencers.
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Signed a - b on operands of width dw, carried in 32-bit containers.
    // The difference is formed one bit wider so the overflow is visible
    // before it is either wrapped back to dw bits or clamped to the dw range.
    function automatic logic signed [31:0] sub_wrap_sat(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input logic               sat,
        input int                 dw
    );
        logic signed [32:0] diff;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        logic signed [32:0] res;
        int                 sh;
        diff = 33'(a) - 33'(b);
        hi   = (33'sd1 <<< (dw - 1)) - 33'sd1;
        lo   = -(33'sd1 <<< (dw - 1));
        sh   = 33 - dw;
        if (sat) begin
            if (diff > hi)
                res = hi;
            else if (diff < lo)
                res = lo;
            else
                res = diff;
        end else begin
            res = (diff <<< sh) >>> sh;
        end
        return 32'(res);
    endfunction

endpackage

// File: rtl/matrix_elem_subtr.sv
// Combinational DW-bit signed subtractor, wrap-around or saturating.
module matrix_elem_subtr
    import nn_pkg::*;
#(
    parameter int DW  = 4,
    parameter int SAT = 0
) (
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [DW-1:0] y
);

    assign y = DW'(sub_wrap_sat(32'(a), 32'(b), (SAT != 0), DW));

endmodule

// File: rtl/matrix_subtr_seq.sv
// Streaming C = A - B sequencer: row-major reads, one shared subtractor,
// valid/ready result stream with whole-pipeline backpressure.
module matrix_subtr_seq
    import nn_pkg::*;
#(
    parameter int ROWS = 3,
    parameter int COLS = 2,
    parameter int DW   = 4,
    parameter int SAT  = 0,
    localparam int N   = ROWS * COLS,
    localparam int AW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_en,
    output logic [AW-1:0]        rd_addr,
    input  logic signed [DW-1:0] a_data,
    input  logic signed [DW-1:0] b_data,
    output logic                 c_valid,
    input  logic                 c_ready,
    output logic [AW-1:0]        c_addr,
    output logic signed [DW-1:0] c_data
);

    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_t                state;
    state_t                state_nx;
    logic                  adv;
    logic                  last_hs;
    logic                  s1_valid;
    logic [AW-1:0]         s1_addr;
    logic signed [DW-1:0]  diff;

    // A stage only moves when the output slot is empty or being drained.
    assign adv     = !c_valid || c_ready;
    assign rd_en   = (state == RUN) && adv;
    assign busy    = (state != IDLE);
    assign last_hs = (state == DRAIN) && c_valid && c_ready && (c_addr == LAST);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (rd_en && (rd_addr == LAST)) state_nx = DRAIN;
            DRAIN:   if (last_hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= last_hs;
        end
    end

    // Stage 0: read issue; the index saturates at LAST until the next start.
    always_ff @(posedge clk) begin
        if (!rst_n)
            rd_addr <= '0;
        else if ((state == IDLE) && start)
            rd_addr <= '0;
        else if (rd_en && (rd_addr != LAST))
            rd_addr <= rd_addr + AW'(1);
    end

    // Stage 1: operand data arrives from memory and is held while rd_en is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
        end else if (adv) begin
            s1_valid <= rd_en;
            s1_addr  <= rd_addr;
        end
    end

    matrix_elem_subtr #(
        .DW  (DW),
        .SAT (SAT)
    ) u_sub (
        .a (a_data),
        .b (b_data),
        .y (diff)
    );

    // Stage 2: registered result presented to the sink.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_valid <= 1'b0;
            c_addr  <= '0;
            c_data  <= '0;
        end else if (adv) begin
            c_valid <= s1_valid;
            c_addr  <= s1_addr;
            c_data  <= diff;
        end
    end

endmodule

// File: tb/tb_matrix_subtr_seq.sv
// Directed bench for matrix_subtr_seq: wrap and saturating instances run in lockstep.
module tb_matrix_subtr_seq;

    localparam int ROWS = 3;
    localparam int COLS = 2;
    localparam int DW   = 4;
    localparam int N    = 6;
    localparam int AW   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic c_ready = 1'b1;
    logic signed [DW-1:0] a_data = '0;
    logic signed [DW-1:0] b_data = '0;

    logic busy, done, rd_en, c_valid;
    logic [AW-1:0] rd_addr, c_addr;
    logic signed [DW-1:0] c_data;

    logic busy_s, done_s, rd_en_s, c_valid_s;
    logic [AW-1:0] rd_addr_s, c_addr_s;
    logic signed [DW-1:0] c_data_s;

    logic signed [DW-1:0] mem_a [N];
    logic signed [DW-1:0] mem_b [N];

    int n_chk = 0;
    int n_fail = 0;
    int got_addr[$];
    int got_data[$];
    int got_sat[$];
    int done_cnt, done_cyc, busy_lo, busy_hi, first_cyc, rd_en_c1, rd_addr_c1;
    int exp1 [N] = '{1, 1, 2, 3, 4, 5};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) begin
            a_data <= mem_a[rd_addr];
            b_data <= mem_b[rd_addr];
        end
    end

    matrix_subtr_seq #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .SAT(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .a_data(a_data), .b_data(b_data),
        .c_valid(c_valid), .c_ready(c_ready), .c_addr(c_addr), .c_data(c_data)
    );

    matrix_subtr_seq #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .SAT(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_s), .done(done_s),
        .rd_en(rd_en_s), .rd_addr(rd_addr_s), .a_data(a_data), .b_data(b_data),
        .c_valid(c_valid_s), .c_ready(c_ready), .c_addr(c_addr_s), .c_data(c_data_s)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seq();
        for (int i = 0; i < N; i++) begin
            mem_a[i] = DW'(i + 1);
            mem_b[i] = (i == 0) ? 4'sd0 : 4'sd1;
        end
    endtask

    // Runs one pass from start; returns during the done cycle (or on timeout).
    task automatic run_pass(input int stall_addr, input int stall_len, input int restart_cyc);
        int cyc = 1;
        int stalled = 0;
        int h_addr = 0;
        int h_data = 0;
        got_addr.delete();
        got_data.delete();
        got_sat.delete();
        done_cnt = 0; done_cyc = -1; busy_lo = -1; busy_hi = -1; first_cyc = -1;
        start = 1'b1;
        c_ready = 1'b1;
        tick();
        start = 1'b0;
        rd_en_c1 = rd_en;
        rd_addr_c1 = rd_addr;
        while (done_cnt == 0 && cyc < 40) begin
            if (busy) begin
                if (busy_lo < 0) busy_lo = cyc;
                busy_hi = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end else begin
                start = (cyc == restart_cyc);
                if (c_valid && int'(c_addr) == stall_addr && stalled < stall_len) begin
                    c_ready = 1'b0;
                    if (stalled == 0) begin
                        h_addr = c_addr;
                        h_data = c_data;
                    end else begin
                        chk("stall_addr", c_addr, h_addr);
                        chk("stall_data", c_data, h_data);
                    end
                    stalled++;
                    #1;
                    chk("stall_rd_en", rd_en, 0);
                end else begin
                    c_ready = 1'b1;
                end
                if (c_valid && c_ready) begin
                    if (first_cyc < 0) first_cyc = cyc;
                    got_addr.push_back(c_addr);
                    got_data.push_back(c_data);
                    got_sat.push_back(c_data_s);
                end
                tick();
                cyc++;
            end
        end
        start = 1'b0;
        c_ready = 1'b1;
        chk("done_seen", done_cnt, 1);
    endtask

    task automatic check_seq(input string tag);
        chk({tag, "_count"}, got_addr.size(), N);
        for (int i = 0; i < N && i < got_addr.size(); i++) begin
            chk({tag, "_addr"}, got_addr[i], i);
            chk({tag, "_data"}, got_data[i], exp1[i]);
            chk({tag, "_sat"}, got_sat[i], exp1[i]);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_c_valid"}, c_valid, 0);
        chk({tag, "_c_addr"}, c_addr, 0);
        chk({tag, "_c_data"}, c_data, 0);
        chk({tag, "_busy_s"}, busy_s, 0);
        chk({tag, "_c_valid_s"}, c_valid_s, 0);
    endtask

    initial begin
        load_seq();
        rst_n = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Plain pass with the sink always ready
        run_pass(-1, 0, -1);
        check_seq("s1");
        chk("s1_done_cyc", done_cyc, 9);
        chk("s1_first_cyc", first_cyc, 3);
        chk("s1_busy_lo", busy_lo, 1);
        chk("s1_busy_hi", busy_hi, 8);
        chk("s1_rd_en_c1", rd_en_c1, 1);
        chk("s1_rd_addr_c1", rd_addr_c1, 0);
        chk("s1_busy_in_done", busy, 0);
        tick();
        chk("s1_done_once", done, 0);
        tick();

        // Overflow on the first two elements
        for (int i = 0; i < N; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        mem_a[0] = 4'sd7;  mem_b[0] = -4'sd8;
        mem_a[1] = -4'sd8; mem_b[1] = 4'sd1;
        run_pass(-1, 0, -1);
        chk("s2_count", got_addr.size(), N);
        if (got_addr.size() >= 2) begin
            chk("s2_wrap0", got_data[0], -1);
            chk("s2_sat0", got_sat[0], 7);
            chk("s2_wrap1", got_data[1], 7);
            chk("s2_sat1", got_sat[1], -8);
        end
        tick();
        tick();

        // Backpressure: sink stalls three cycles on element 2
        load_seq();
        run_pass(2, 3, -1);
        check_seq("s3");
        chk("s3_done_cyc", done_cyc, 12);
        chk("s3_busy_hi", busy_hi, 11);
        tick();
        chk("s3_done_once", done, 0);
        tick();

        // Start pulsed while busy is ignored
        run_pass(-1, 0, 4);
        check_seq("s4");
        chk("s4_done_cyc", done_cyc, 9);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s4_no_extra_done", done, 0);
            chk("s4_no_restart", busy, 0);
        end

        // Reset in the middle of a pass
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        chk("s5_busy_before", busy, 1);
        rst_n = 1'b0;
        tick();
        check_idle_outputs("s5_rst");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s5_no_done", done, 0);
            chk("s5_idle", busy, 0);
        end
        run_pass(-1, 0, -1);
        check_seq("s5");
        chk("s5_done_cyc", done_cyc, 9);
        tick();
        tick();

        // Back-to-back passes: second start lands in the done cycle
        run_pass(-1, 0, -1);
        chk("s6a_done_cyc", done_cyc, 9);
        run_pass(-1, 0, -1);
        chk("s6b_rd_en_c1", rd_en_c1, 1);
        chk("s6b_rd_addr_c1", rd_addr_c1, 0);
        chk("s6b_busy_lo", busy_lo, 1);
        check_seq("s6b");
        chk("s6b_done_cyc", done_cyc, 9);
        tick();
        chk("s6b_done_once", done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
